// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M iterative multiply/divide sequencer.
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } muldiv_state_t;

  // funct3 encodings (instr[14:12]) of the M extension.
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [31:0] INT_MIN  = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

  // rs1 is signed for MULH, MULHSU, DIV and REM.
  function automatic logic signed_a(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  // rs2 is signed for MULH, DIV and REM.
  function automatic logic signed_b(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Operand/accumulator/quotient registers, shared adder-subtractor and sign fixup.
// Ports:
//   clk, rst        clock, async active-high reset
//   load            latch funct3, operand magnitudes and signs (normal start)
//   spec_load       write spec_value straight into result (corner case start)
//   spec_value      final result for a corner case
//   step            perform one shift-add / restoring-divide iteration
//   finish          last iteration: write sign-fixed result
//   funct3, op_a, op_b  instruction encoding and operands
//   result          registered result, held until the next write
module muldiv_datapath
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            spec_load,
  input  logic [XLEN-1:0] spec_value,
  input  logic            step,
  input  logic            finish,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic [XLEN-1:0] result
);

  localparam int unsigned PW = 2 * XLEN;  // product width
  localparam int unsigned AW = XLEN + 2;  // adder width, keeps the borrow for divide

  logic [2:0]      f3_q;
  logic [XLEN-1:0] a_mag_q, b_mag_q;
  logic            sign_a_q, sign_b_q;
  logic [PW-1:0]   prod_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quot_q;
  logic [XLEN-1:0] result_q;

  logic            neg_a_in, neg_b_in;
  logic [XLEN-1:0] a_mag_in, b_mag_in;
  logic            is_div;
  logic [XLEN:0]   div_shift;
  logic [AW-1:0]   add_a, add_b, sum;
  logic [XLEN:0]   mul_hi;
  logic [PW-1:0]   prod_nxt;
  logic            q_bit;
  logic [XLEN-1:0] rem_nxt, quot_nxt;
  logic [PW-1:0]   prod_fix;
  logic [XLEN-1:0] quot_fix, rem_fix, fix_res;

  // Operand magnitudes; unsigned operands keep a zero sign.
  always_comb begin
    neg_a_in = signed_a(funct3) && op_a[XLEN-1];
    neg_b_in = signed_b(funct3) && op_b[XLEN-1];
    a_mag_in = neg_a_in ? -op_a : op_a;
    b_mag_in = neg_b_in ? -op_b : op_b;
  end

  // Shared adder: multiply adds the multiplicand into the high half,
  // divide subtracts the divisor from the shifted 33-bit partial remainder.
  always_comb begin
    is_div    = f3_q[2];
    div_shift = {rem_q, quot_q[XLEN-1]};
    add_a     = is_div ? {1'b0, div_shift} : {2'b00, prod_q[PW-1:XLEN]};
    add_b     = is_div ? ~{2'b00, b_mag_q} : {2'b00, a_mag_q};
    sum       = add_a + add_b + AW'(is_div);

    mul_hi    = prod_q[0] ? sum[XLEN:0] : {1'b0, prod_q[PW-1:XLEN]};
    prod_nxt  = {mul_hi, prod_q[XLEN-1:1]};

    // A clear borrow bit means the shifted remainder was >= divisor.
    q_bit     = ~sum[AW-1];
    rem_nxt   = q_bit ? sum[XLEN-1:0] : div_shift[XLEN-1:0];
    quot_nxt  = {quot_q[XLEN-2:0], q_bit};
  end

  // Sign fixup on the values produced by the final iteration.
  always_comb begin
    prod_fix = (sign_a_q ^ sign_b_q) ? -prod_nxt : prod_nxt;
    quot_fix = (sign_a_q ^ sign_b_q) ? -quot_nxt : quot_nxt;
    rem_fix  = sign_a_q ? -rem_nxt : rem_nxt;
    fix_res  = '0;
    unique case (f3_q)
      F3_MUL:                        fix_res = prod_fix[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU:  fix_res = prod_fix[PW-1:XLEN];
      F3_DIV, F3_DIVU:               fix_res = quot_fix;
      F3_REM, F3_REMU:               fix_res = rem_fix;
      default:                       fix_res = '0;
    endcase
  end

  // Operand and iteration registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f3_q     <= '0;
      a_mag_q  <= '0;
      b_mag_q  <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      prod_q   <= '0;
      rem_q    <= '0;
      quot_q   <= '0;
    end else if (load) begin
      f3_q     <= funct3;
      a_mag_q  <= a_mag_in;
      b_mag_q  <= b_mag_in;
      sign_a_q <= neg_a_in;
      sign_b_q <= neg_b_in;
      prod_q   <= {XLEN'(0), b_mag_in};
      rem_q    <= '0;
      quot_q   <= a_mag_in;
    end else if (step) begin
      if (is_div) begin
        rem_q  <= rem_nxt;
        quot_q <= quot_nxt;
      end else begin
        prod_q <= prod_nxt;
      end
    end
  end

  // Result register: holds until the next completed operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
    end else if (spec_load) begin
      result_q <= spec_value;
    end else if (finish) begin
      result_q <= fix_res;
    end
  end

  assign result = result_q;

endmodule

// File: rtl/muldiv_seq.sv
// RV32M iterative multiply/divide sequencer: FSM, iteration counter,
// divide corner-case detection and pipeline stall/valid handshake.
// Ports:
//   clk, rst   clock, async active-high reset
//   start      valid M instruction in EX (level, sampled in IDLE)
//   funct3     M-extension operation select
//   op_a, op_b rs1 / rs2 values
//   flush      pipeline flush, aborts any operation
//   stall      combinational pipeline freeze
//   result     registered result, meaningful while valid
//   valid      one-cycle completion pulse
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned ITER = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            stall,
  output logic [XLEN-1:0] result,
  output logic            valid
);

  localparam int unsigned CNT_W = $clog2(ITER);

  muldiv_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             valid_q;

  logic            accept;
  logic            div_zero, sgn_ovf, special;
  logic [XLEN-1:0] spec_value;
  logic            last, step, finish;

  // Corner cases resolved without iterating.
  always_comb begin
    div_zero   = funct3[2] && (op_b == '0);
    sgn_ovf    = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                 (op_a == INT_MIN) && (op_b == ALL_ONES);
    special    = div_zero || sgn_ovf;
    // funct3[1] separates REM/REMU from DIV/DIVU.
    if (div_zero) spec_value = funct3[1] ? op_a : ALL_ONES;
    else          spec_value = funct3[1] ? '0   : INT_MIN;
  end

  always_comb begin
    accept = (state_q == IDLE) && start && !flush;
    last   = (cnt_q == CNT_W'(ITER - 1));
    step   = (state_q == RUN) && !flush;
    finish = step && last;
    stall  = accept || (state_q == RUN);
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = special ? DONE : RUN;
      RUN: begin
        if (flush)     state_d = IDLE;
        else if (last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, counter and valid registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= (state_d == DONE);
      if (state_q == RUN) cnt_q <= cnt_q + CNT_W'(1);
      else                cnt_q <= '0;
    end
  end

  assign valid = valid_q;

  muldiv_datapath #(
    .XLEN(XLEN)
  ) u_datapath (
    .clk       (clk),
    .rst       (rst),
    .load      (accept && !special),
    .spec_load (accept && special),
    .spec_value(spec_value),
    .step      (step),
    .finish    (finish),
    .funct3    (funct3),
    .op_a      (op_a),
    .op_b      (op_b),
    .result    (result)
  );

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed cases, aborts and random ops
// compared against a plain-arithmetic RV32M reference model.
module tb_muldiv_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        flush;
  logic        stall;
  logic [31:0] result;
  logic        valid;

  int tests = 0;
  int fails = 0;
  logic [31:0] last_res = 32'h0;

  muldiv_seq #(.XLEN(32), .ITER(32)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .flush(flush),
    .stall(stall), .result(result), .valid(valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // RV32M semantics straight from the ISA definition.
  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    logic ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'h0, a});
    ub  = longint'({32'h0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = 64'h0;
    case (f3)
      3'd0: begin p = 64'(sa * sb); return p[31:0];  end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = 64'(ua * ub); return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf)    return 32'h8000_0000;
        return 32'(sa / sb);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf)    return 32'h0;
        return 32'(sa % sb);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
    logic is_div, signed_div;
    is_div     = (f3 >= 3'd4);
    signed_div = (f3 == 3'd4) || (f3 == 3'd6);
    if (is_div && (b == 0)) return 1;
    if (signed_div && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) return 1;
    return 33;
  endfunction

  // One operation with start held from cycle 0 up to the valid cycle.
  // Entered and left at 1 time unit after a rising edge.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input bit keep);
    int lat;
    lat = ref_latency(f3, a, b);
    @(posedge clk); #1;
    funct3 = f3; op_a = a; op_b = b; start = 1'b1;
    #1;
    check({tag, " c0 stall"}, 64'(stall), 64'(1));
    check({tag, " c0 valid"}, 64'(valid), 64'(0));
    for (int k = 1; k <= lat; k++) begin
      @(posedge clk); #1;
      if (k < lat) begin
        if (valid !== 1'b0 || stall !== 1'b1) begin
          check({tag, " busy valid"}, 64'(valid), 64'(0));
          check({tag, " busy stall"}, 64'(stall), 64'(1));
        end
      end else begin
        check({tag, " done valid"},  64'(valid),  64'(1));
        check({tag, " done stall"},  64'(stall),  64'(0));
        check({tag, " done result"}, 64'(result), 64'(exp));
      end
    end
    last_res = exp;
    if (!keep) start = 1'b0;
  endtask

  initial begin
    logic [2:0]  rf3;
    logic [31:0] ra, rb;
    rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = 3'd0; op_a = '0; op_b = '0;
    #1;
    check("reset result", 64'(result), 64'(0));
    check("reset valid",  64'(valid),  64'(0));
    check("reset stall",  64'(stall),  64'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Multiply.
    run_op("MUL 7*-3",   3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
    run_op("MULHU -1*-1",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    run_op("MULH -1*-1",   3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
    run_op("MULHSU -1*-1", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

    // Divide.
    run_op("DIV -7/2",   3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
    run_op("REM -7/2",   3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
    run_op("DIVU 100/7", 3'd5, 32'd100,       32'd7, 32'd14,        1'b0);
    run_op("REMU 100/7", 3'd7, 32'd100,       32'd7, 32'd2,         1'b0);

    // Corner cases, latency 1.
    run_op("DIVU 5/0",     3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b0);
    run_op("REM 5/0",      3'd6, 32'd5,         32'd0,         32'd5,         1'b0);
    run_op("DIV ovf",      3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    run_op("REM ovf",      3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1'b0);
    run_op("MULHU final",  3'd3, 32'h1234_5678, 32'h9ABC_DEF0,
           ref_result(3'd3, 32'h1234_5678, 32'h9ABC_DEF0), 1'b0);

    // Flush in cycle 10 of a DIV.
    @(posedge clk); #1;
    funct3 = 3'd4; op_a = 32'd1000; op_b = 32'd3; start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
    end
    flush = 1'b1; start = 1'b0;
    #1 check("flush c10 stall", 64'(stall), 64'(1));
    @(posedge clk); #1;
    flush = 1'b0;
    #1;
    check("flush c11 stall",  64'(stall),  64'(0));
    check("flush c11 valid",  64'(valid),  64'(0));
    check("flush result held", 64'(result), 64'(last_res));
    for (int k = 12; k <= 40; k++) begin
      @(posedge clk); #1;
      if (valid !== 1'b0) check("flush no valid", 64'(valid), 64'(0));
    end
    check("flush quiet valid", 64'(valid), 64'(0));

    // Flush together with start in IDLE.
    funct3 = 3'd0; op_a = 32'd9; op_b = 32'd9; start = 1'b1; flush = 1'b1;
    #1 check("idle flush stall", 64'(stall), 64'(0));
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    #1;
    check("idle flush next stall", 64'(stall), 64'(0));
    check("idle flush next valid", 64'(valid), 64'(0));
    repeat (3) @(posedge clk);
    #1 check("idle flush no valid", 64'(valid), 64'(0));

    // Asynchronous reset in cycle 20 of a MUL.
    @(posedge clk); #1;
    funct3 = 3'd0; op_a = 32'h0001_2345; op_b = 32'h0000_0055; start = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
    end
    check("pre-rst stall", 64'(stall), 64'(1));
    #2;
    rst = 1'b1; start = 1'b0;
    #1;
    check("rst result", 64'(result), 64'(0));
    check("rst valid",  64'(valid),  64'(0));
    check("rst stall",  64'(stall),  64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    last_res = 32'h0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (valid !== 1'b0) check("post-rst no valid", 64'(valid), 64'(0));
    end
    check("post-rst result", 64'(result), 64'(0));

    // Back-to-back with start held through DONE.
    run_op("B2B 3*4", 3'd0, 32'd3, 32'd4, 32'd12, 1'b1);
    run_op("B2B 5*6", 3'd0, 32'd5, 32'd6, 32'd30, 1'b0);
    @(posedge clk); #1;
    check("B2B result hold", 64'(result), 64'(30));
    check("B2B idle valid",  64'(valid),  64'(0));

    // Random operations against the reference model.
    for (int n = 0; n < 40; n++) begin
      rf3 = 3'($urandom_range(7, 0));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(7, 0))
        0: rb = 32'h0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: begin ra = 32'($urandom_range(1000, 0)); rb = 32'($urandom_range(50, 1)); end
        3: rb = 32'hFFFF_FFFF - 32'($urandom_range(3, 0));
        default: ;
      endcase
      run_op($sformatf("rand%0d f3=%0d", n, rf3), rf3, ra, rb, ref_result(rf3, ra, rb), 1'b0);
    end

    @(posedge clk); #1;
    check("final idle stall", 64'(stall), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
